col_output_serializer: RTL and testbench

//  Parametrised successor to the column output controller. It captures one wave of systolic-array

---
 rtl/col_output_serializer.sv | 131 +++++++++++++
 tb/tb_col_output_serializer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/col_output_serializer.sv
// Captures one wave of systolic-array column results into a DEPTH-entry buffer and
// drains it one word per cycle over a valid/ready port, in full or pack mode.
module col_output_serializer #(
   parameter int unsigned NCOLS  = 8,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 2
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [NCOLS*DATA_W-1:0]    in_r,
   input  logic [NCOLS-1:0]           in_v,
   input  logic                       in_pack,
   output logic                       in_ready,
   output logic [DATA_W-1:0]          out_r,
   output logic [$clog2(NCOLS)-1:0]   out_col,
   output logic                       out_last,
   output logic                       rvalid,
   input  logic                       rread,
   output logic                       drop_err
);

   localparam int unsigned CW = $clog2(NCOLS);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned NW = $clog2(DEPTH + 1);

   logic [NCOLS*DATA_W-1:0] mem_r    [DEPTH];
   logic [NCOLS-1:0]        mem_v    [DEPTH];
   logic                    mem_pack [DEPTH];

   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [NW-1:0] count;
   logic [CW-1:0] sc;

   logic [NCOLS*DATA_W-1:0] head_r;
   logic [NCOLS-1:0]        head_v;
   logic                    head_pack;

   logic              push;
   logic              pending;
   logic              load;
   logic              pop;
   logic [CW-1:0]     cur;
   logic              cur_last;
   logic              found;
   logic              above;
   logic [DATA_W-1:0] word;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign in_ready  = (count != NW'(DEPTH));
   assign push      = (|in_v) && in_ready;
   assign pending   = (count != '0);
   assign head_r    = mem_r[rptr];
   assign head_v    = mem_v[rptr];
   assign head_pack = mem_pack[rptr];

   // Column selection: full mode walks sc; pack mode jumps to the lowest set mask bit at or
   // above sc, so consecutive words need no idle cycle in between.
   always_comb begin
      cur      = sc;
      found    = 1'b0;
      above    = 1'b0;
      word     = '0;
      cur_last = 1'b0;
      if (head_pack) begin
         for (int unsigned i = 0; i < NCOLS; i++) begin
            if (!found && head_v[i] && (i >= 32'(sc))) begin
               cur   = CW'(i);
               found = 1'b1;
            end
         end
      end
      for (int unsigned i = 0; i < NCOLS; i++) begin
         if (CW'(i) == cur)
            word = head_v[i] ? head_r[i*DATA_W +: DATA_W] : '0;
         if ((i > 32'(cur)) && head_v[i])
            above = 1'b1;
      end
      cur_last = head_pack ? !above : (cur == CW'(NCOLS - 1));
   end

   assign load = pending && (!rvalid || rread);
   assign pop  = load && cur_last;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_r[wptr]    <= in_r;
         mem_v[wptr]    <= in_v;
         mem_pack[wptr] <= in_pack;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         sc       <= '0;
         rvalid   <= 1'b0;
         out_r    <= '0;
         out_col  <= '0;
         out_last <= 1'b0;
         drop_err <= 1'b0;
      end else begin
         if (push)
            wptr <= ptr_inc(wptr);
         if (pop)
            rptr <= ptr_inc(rptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (load) begin
            out_r    <= word;
            out_col  <= cur;
            out_last <= cur_last;
            rvalid   <= 1'b1;
            sc       <= cur_last ? '0 : cur + 1'b1;
         end else if (!rvalid || rread) begin
            rvalid <= 1'b0;
         end
         if ((|in_v) && !in_ready)
            drop_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_col_output_serializer.sv
// Directed and randomized checks of col_output_serializer against a queue-based word model.
module tb_col_output_serializer;

   localparam int unsigned NCOLS  = 8;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 2;

   logic                    clk = 1'b0;
   logic                    rstn;
   logic [NCOLS*DATA_W-1:0] in_r;
   logic [NCOLS-1:0]        in_v;
   logic                    in_pack;
   logic                    in_ready;
   logic [DATA_W-1:0]       out_r;
   logic [2:0]              out_col;
   logic                    out_last;
   logic                    rvalid;
   logic                    rread;
   logic                    drop_err;

   col_output_serializer #(.NCOLS(NCOLS), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rstn(rstn), .in_r(in_r), .in_v(in_v), .in_pack(in_pack),
      .in_ready(in_ready), .out_r(out_r), .out_col(out_col), .out_last(out_last),
      .rvalid(rvalid), .rread(rread), .drop_err(drop_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DATA_W-1:0] d;
      logic [2:0]        c;
      logic              l;
   } word_t;

   // Model: words still to be emitted, the word in the output register, and the sticky flag.
   word_t pend[$];
   word_t held;
   bit    held_v;
   bit    drop_exp;

   int n_checks = 0;
   int n_pass   = 0;
   int xfers    = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic int waves_buffered();
      int n = 0;
      foreach (pend[i]) if (pend[i].l) n++;
      return n;
   endfunction

   task automatic push_wave(input logic [NCOLS-1:0] v, input logic [NCOLS*DATA_W-1:0] r,
                            input logic p);
      int hi = NCOLS - 1;
      word_t w;
      if (p) begin
         hi = 0;
         for (int c = 0; c < NCOLS; c++) if (v[c]) hi = c;
      end
      for (int c = 0; c < NCOLS; c++) begin
         if (!p || v[c]) begin
            w.d = v[c] ? r[c*DATA_W +: DATA_W] : '0;
            w.c = 3'(c);
            w.l = (c == hi);
            pend.push_back(w);
         end
      end
   endtask

   task automatic model_reset();
      pend.delete();
      held_v   = 0;
      held     = '{d: '0, c: '0, l: 1'b0};
      drop_exp = 0;
   endtask

   task automatic model_edge();
      bit ready_b = (waves_buffered() != DEPTH);
      if (pend.size() > 0 && (!held_v || rread)) begin
         held   = pend.pop_front();
         held_v = 1;
      end else if (!held_v || rread) begin
         held_v = 0;
      end
      if (|in_v) begin
         if (ready_b) push_wave(in_v, in_r, in_pack);
         else drop_exp = 1;
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".in_ready"}, in_ready, (waves_buffered() != DEPTH));
      check({tag, ".rvalid"}, rvalid, held_v);
      check({tag, ".drop_err"}, drop_err, drop_exp);
      if (held_v) begin
         check({tag, ".out_r"}, out_r, held.d);
         check({tag, ".out_col"}, out_col, held.c);
         check({tag, ".out_last"}, out_last, held.l);
      end
   endtask

   task automatic cycle(input string tag, input logic [NCOLS-1:0] v,
                        input logic [NCOLS*DATA_W-1:0] r, input logic p, input logic rd);
      in_v = v; in_r = r; in_pack = p; rread = rd;
      #1;
      if (rvalid && rd) xfers++;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all(tag);
   endtask

   function automatic logic [NCOLS*DATA_W-1:0] seq_data();
      logic [NCOLS*DATA_W-1:0] r;
      for (int c = 0; c < NCOLS; c++) r[c*DATA_W +: DATA_W] = DATA_W'(100 * c + 1);
      return r;
   endfunction

   function automatic logic [NCOLS*DATA_W-1:0] rnd_data();
      logic [NCOLS*DATA_W-1:0] r;
      for (int c = 0; c < NCOLS; c++) r[c*DATA_W +: DATA_W] = $urandom;
      return r;
   endfunction

   logic [NCOLS*DATA_W-1:0] sq;
   logic [NCOLS-1:0]        rv;

   initial begin
      model_reset();
      rstn = 1'b0; in_v = '0; in_r = '0; in_pack = 1'b0; rread = 1'b0;
      repeat (2) @(negedge clk);
      check("reset.out_r", out_r, 0);
      check("reset.out_col", out_col, 0);
      check("reset.out_last", out_last, 0);
      compare_all("reset");
      rstn = 1'b1;
      sq = seq_data();

      // 1: full mode, all columns valid
      cycle("t1", 8'hFF, sq, 1'b0, 1'b1);
      repeat (10) cycle("t1", '0, '0, 1'b0, 1'b1);

      // 2: pack mode, sparse mask
      cycle("t2", 8'b1010_0100, sq, 1'b1, 1'b1);
      repeat (5) cycle("t2", '0, '0, 1'b0, 1'b1);

      // 3: full mode, only column 0 valid
      cycle("t3", 8'h01, sq, 1'b0, 1'b1);
      repeat (10) cycle("t3", '0, '0, 1'b0, 1'b1);

      // 4: stall, overflow the buffer, then drain
      cycle("t4", 8'hFF, sq, 1'b0, 1'b0);
      cycle("t4", 8'hFF, sq, 1'b0, 1'b0);
      cycle("t4", 8'hFF, sq, 1'b0, 1'b0);
      repeat (3) cycle("t4", '0, '0, 1'b0, 1'b0);
      xfers = 0;
      repeat (20) cycle("t4", '0, '0, 1'b0, 1'b1);
      check("t4.xfers", xfers, 16);

      // 5: toggling rread during a pack-mode drain
      cycle("t5", 8'b0110_1011, sq, 1'b1, 1'b1);
      for (int i = 0; i < 14; i++) cycle("t5", '0, '0, 1'b0, 1'(i % 2 == 0));

      // 6: reset in the middle of a drain
      cycle("t6", 8'hFF, sq, 1'b0, 1'b0);
      cycle("t6", 8'hFF, sq, 1'b0, 1'b1);
      cycle("t6", '0, '0, 1'b0, 1'b1);
      cycle("t6", '0, '0, 1'b0, 1'b1);
      rstn = 1'b0;
      #1;
      model_reset();
      check("t6.rvalid_async", rvalid, 0);
      check("t6.drop_err_async", drop_err, 0);
      @(negedge clk);
      compare_all("t6.in_reset");
      rstn = 1'b1;
      repeat (6) cycle("t6.after", '0, '0, 1'b0, 1'b1);
      cycle("t6.after", 8'h81, sq, 1'b1, 1'b1);
      repeat (4) cycle("t6.after", '0, '0, 1'b0, 1'b1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         rv = ($urandom_range(0, 2) == 0) ? '0 : NCOLS'($urandom);
         cycle("rnd", rv, rnd_data(), 1'($urandom), 1'($urandom_range(0, 3) != 0));
      end
      repeat (40) cycle("rnd.drain", '0, '0, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
